// File: rtl/cga_pkg.sv
// Shared definitions for the CGA sequencer: fetch-phase constants, the
// CPU-window arbiter state type and the phase-extraction helper.
package cga_pkg;

  // Phase positions within one character period.
  localparam logic [4:0] PH_CHAR   = 5'd0;
  localparam logic [4:0] PH_ATT    = 5'd2;
  localparam logic [4:0] PH_ROM    = 5'd3;
  localparam logic [4:0] PH_END_HI = 5'd15;
  localparam logic [4:0] PH_END_LO = 5'd31;

  // Last cycle index of the 4-cycle CPU window (counted 0..3).
  localparam logic [1:0] WIN_LAST  = 2'd3;

  // CPU VRAM window arbiter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

  // Phase within the current character: 16-clock characters in
  // 80-column timing, 32-clock characters otherwise.
  function automatic logic [4:0] seq_phase(input logic [4:0] seq, input logic hres);
    seq_phase = hres ? {1'b0, seq[3:0]} : seq;
  endfunction

endpackage

// File: rtl/cga_vram_arbiter.sv
// CPU VRAM window arbiter. Opens a 4-clock CPU window at a slot phase when
// the CPU is requesting, then acknowledges for one clock.
// Optional build macro CGA_SNOW_EN: flags windows that would have produced
// snow on a real CGA so the downstream mux can substitute the CPU byte on
// the next character fetch. Without the macro, snow is constant 0.
module cga_vram_arbiter
  import cga_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic slot_hit,        // current cycle is a CPU slot phase
  input  logic char_hit,        // current cycle is the character fetch phase
  input  logic hres_lat,        // latched 80-column mode
  input  logic grph_mode,
  input  logic display_enable,
  input  logic cpu_req,
  output logic vram_addr_sel,
  output logic cpu_ack,
  output logic snow
);

  arb_state_e state_r;
  arb_state_e state_nxt_s;
  logic [1:0] win_r;
  logic [1:0] win_nxt_s;
  logic       sel_r;
  logic       sel_nxt_s;
  logic       ack_r;
  logic       ack_nxt_s;

  // Next-state and next-output decode for the window FSM.
  always_comb begin
    state_nxt_s = state_r;
    win_nxt_s   = win_r;
    case (state_r)
      IDLE: begin
        if (slot_hit && cpu_req) begin
          state_nxt_s = GRANT;
          win_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = IDLE;
          win_nxt_s   = 2'd0;
        end
      end
      GRANT: begin
        if (win_r == WIN_LAST) begin
          state_nxt_s = ACK;
          win_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = GRANT;
          win_nxt_s   = win_r + 2'd1;
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
        win_nxt_s   = 2'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        win_nxt_s   = 2'd0;
      end
    endcase
    sel_nxt_s = (state_nxt_s != GRANT);
    ack_nxt_s = (state_nxt_s == ACK);
  end

  // State, window counter and registered bus-select / ack outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      win_r   <= 2'd0;
      sel_r   <= 1'b1;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      win_r   <= win_nxt_s;
      sel_r   <= sel_nxt_s;
      ack_r   <= ack_nxt_s;
    end
  end

  assign vram_addr_sel = sel_r;
  assign cpu_ack       = ack_r;

`ifdef CGA_SNOW_EN
  logic grant_start_s;
  logic snow_pend_r;
  logic snow_r;

  assign grant_start_s = (state_r == IDLE) && slot_hit && cpu_req;

  // Arm on a grant taken during active 80-column text display; fire with the next char fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snow_pend_r <= 1'b0;
      snow_r      <= 1'b0;
    end else begin
      snow_r <= snow_pend_r && char_hit;
      if (grant_start_s && hres_lat && !grph_mode && display_enable) begin
        snow_pend_r <= 1'b1;
      end else if (char_hit) begin
        snow_pend_r <= 1'b0;
      end
    end
  end

  assign snow = snow_r;
`else
  logic unused_s;
  assign unused_s = ^{char_hit, hres_lat, grph_mode, display_enable};
  assign snow     = 1'b0;
`endif

endmodule

// File: rtl/cga_sequencer.sv
// CGA master timing generator: free-running sequence counter, latched
// column mode, registered fetch/ROM/pipeline/CRTC strobes and the CPU
// VRAM window arbiter.
// Optional build macro CGA_SNOW_EN (handled in cga_vram_arbiter) enables
// the snow artefact flag; without it snow is constant 0.
module cga_sequencer
  import cga_pkg::*;
#(
  parameter int unsigned CPU_SLOT = 8,
  parameter int unsigned SEQ_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hres_mode,
  input  logic             display_enable,
  input  logic             grph_mode,
  input  logic             cpu_req,
  output logic [SEQ_W-1:0] clk_seq,
  output logic             crtc_clk,
  output logic             vram_read_char,
  output logic             vram_read_att,
  output logic             vram_addr_sel,
  output logic             charrom_read,
  output logic             disp_pipeline,
  output logic             cpu_ack,
  output logic             snow
);

  localparam logic [SEQ_W-1:0] SEQ_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};
  localparam logic [SEQ_W-1:0] SEQ_LAST = {SEQ_W{1'b1}};
  localparam logic [4:0]       SLOT_A   = 5'(CPU_SLOT);
  localparam logic [4:0]       SLOT_B   = 5'(CPU_SLOT + 16);

  logic [SEQ_W-1:0] seq_r;
  logic             hres_r;
  logic [4:0]       phase_s;
  logic             char_hit_s;
  logic             att_hit_s;
  logic             rom_hit_s;
  logic             end_hit_s;
  logic             slot_hit_s;

  logic             char_r;
  logic             att_r;
  logic             rom_r;
  logic             disp_r;
  logic             crtc_r;

  // Free-running sequence counter, wraps at the top of its range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_r <= {SEQ_W{1'b0}};
    end else begin
      seq_r <= seq_r + SEQ_ONE;
    end
  end

  // Column mode is only taken at the last count so a character is never split.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hres_r <= 1'b0;
    end else if (seq_r == SEQ_LAST) begin
      hres_r <= hres_mode;
    end else begin
      hres_r <= hres_r;
    end
  end

  // Phase decode of the current count under the latched column mode.
  always_comb begin
    phase_s    = seq_phase(seq_r[4:0], hres_r);
    char_hit_s = (phase_s == PH_CHAR);
    att_hit_s  = (phase_s == PH_ATT);
    rom_hit_s  = (phase_s == PH_ROM);
    if (hres_r) begin
      end_hit_s  = (phase_s == PH_END_HI);
      slot_hit_s = (phase_s == SLOT_A);
    end else begin
      end_hit_s  = (phase_s == PH_END_LO);
      slot_hit_s = (phase_s == SLOT_A) || (phase_s == SLOT_B);
    end
  end

  // Strobes appear one clock after their phase is decoded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_r <= 1'b0;
      att_r  <= 1'b0;
      rom_r  <= 1'b0;
      disp_r <= 1'b0;
      crtc_r <= 1'b0;
    end else begin
      char_r <= char_hit_s;
      att_r  <= att_hit_s;
      rom_r  <= rom_hit_s;
      disp_r <= end_hit_s;
      crtc_r <= end_hit_s;
    end
  end

  cga_vram_arbiter u_arbiter (
    .clk            (clk),
    .reset          (reset),
    .slot_hit       (slot_hit_s),
    .char_hit       (char_hit_s),
    .hres_lat       (hres_r),
    .grph_mode      (grph_mode),
    .display_enable (display_enable),
    .cpu_req        (cpu_req),
    .vram_addr_sel  (vram_addr_sel),
    .cpu_ack        (cpu_ack),
    .snow           (snow)
  );

  assign clk_seq        = seq_r;
  assign vram_read_char = char_r;
  assign vram_read_att  = att_r;
  assign charrom_read   = rom_r;
  assign disp_pipeline  = disp_r;
  assign crtc_clk       = crtc_r;

endmodule

// File: doc/cga_sequencer.md
Name: cga_sequencer

Overview:
- Master timing generator for the CGA pipeline; sits directly upstream of the pixel/attribute stage.
- Free-running 5-bit clk_seq drives the pixel stage.
- Produces the VRAM fetch strobes (char, attr), the character-ROM read strobe, the display-pipeline advance strobe and the CRTC character-clock enable.
- Arbitrates one CPU VRAM slot per half-character window via a req/ack handshake.

Parameters:
- CPU_SLOT, 8, phase (0-15) at which a CPU VRAM window opens; window is 4 clocks.
- SEQ_W, 5, clk_seq width; fixed at 5, not to be overridden.

Ports:
- clk  in  1  pixel master clock (28.636 MHz)
- reset  in  1  asynchronous, active-high reset
- hres_mode  in  1  1 = 80-column timing (16-clk char), 0 = 40-column/graphics (32-clk char)
- display_enable  in  1  from CRTC; used only by the optional feature
- grph_mode  in  1  graphics mode; used only by the optional feature
- cpu_req  in  1  CPU requests a VRAM access (level)
- clk_seq  out  5  sequence counter to pixel stage
- crtc_clk  out  1  one-cycle CRTC character clock enable
- vram_read_char  out  1  latch strobe, character/pixel byte 0
- vram_read_att  out  1  latch strobe, attribute/pixel byte 1
- vram_addr_sel  out  1  1 = CRTC address on VRAM bus, 0 = CPU
- charrom_read  out  1  character-ROM lookup strobe
- disp_pipeline  out  1  attribute/cursor/enable pipeline advance
- cpu_ack  out  1  one-cycle CPU access complete
- snow  out  1  CPU-contention artefact flag (optional feature)

Behaviour:
- Reset: clk_seq=0; all strobes, cpu_ack and snow = 0; vram_addr_sel=1; internal hres latch=0; no pending grant.
- clk_seq increments every clk and wraps 31->0. No stall, no enable.
- hres_mode is sampled into an internal latch only in the cycle clk_seq==31, so mode changes never split a character. All decode uses the latched value.
- Phase p = latched hres ? clk_seq[3:0] : clk_seq[4:0].
- All outputs are registered; each pulse is asserted in the cycle after clk_seq equals the listed value.
- Fetch schedule, one-cycle pulses:
  - vram_read_char at p==0.
  - vram_read_att at p==2.
  - charrom_read at p==3. This guarantees char_byte is stable before the pixel stage's load at clk_seq==4.
  - disp_pipeline at p==15 (hres) or p==31 (lores).
  - crtc_clk at p==15 (hres) or p==31 (lores).
- CPU slots: hres p==CPU_SLOT; lores p==CPU_SLOT and p==CPU_SLOT+16.
- Arbiter FSM, states IDLE, GRANT, ACK:
  - IDLE -> GRANT at a slot phase if cpu_req==1. vram_addr_sel=0 for the 4 cycles of GRANT.
  - GRANT -> ACK after the 4th cycle. cpu_ack=1 for exactly one cycle.
  - ACK -> IDLE.
  - cpu_req sampled only at the slot phase. If it is dropped mid-window, the access still completes and acks.
  - If cpu_req is still high in IDLE at the next slot, a new access is served. The requester must drop req the cycle after ack.
  - A request arriving 1 cycle after a slot waits for the next slot: worst-case latency 16 clocks hres/lores, plus 4 clocks of window.
- The CPU window never overlaps p 0-3, so CRTC fetches are never displaced.
- Mode change while in GRANT completes the current window unchanged. The new slot positions apply from the next character.
- Reset asserted mid-window: immediate return to IDLE, no ack.

Optional Feature:
- CGA_SNOW_EN defined:
  - Condition: a GRANT that begins while latched hres==1, grph_mode==0 and display_enable==1.
  - Effect: snow pulses together with the next vram_read_char. The downstream mux then substitutes the CPU data byte, emulating IBM CGA snow.
- Undefined: snow is tied to 0 and no extra logic is inferred.

Decomposition:
- Shared package cga_pkg holds:
  - Phase constants: PH_CHAR=0, PH_ATT=2, PH_ROM=3, PH_END_HI=15, PH_END_LO=31.
  - Arbiter state typedef: IDLE/GRANT/ACK.
- One sub-module, cga_vram_arbiter: owns the FSM, cpu_ack, vram_addr_sel and snow. The top keeps the counter and strobe decode.

Test Plan:
- Reset release, hres=1 -> over 32 clocks, vram_read_char in cycles after clk_seq 0 and 16; vram_read_att after 2 and 18; charrom_read after 3 and 19; crtc_clk after 15 and 31.
- hres=0 -> exactly one vram_read_char per 32 clocks (after clk_seq 0); crtc_clk only after clk_seq 31.
- Toggle hres at clk_seq==10 -> old timing persists through clk_seq 31; new timing from the next wrap.
- cpu_req rises at clk_seq 9, hres=1 -> vram_addr_sel=0 after clk_seq 24..27; cpu_ack one pulse following; no fetch strobe displaced.
- Assert reset during GRANT -> vram_addr_sel returns to 1 immediately; cpu_ack never pulses; clk_seq=0.
- CGA_SNOW_EN, hres=1, text mode, display_enable=1, CPU grant -> snow=1 coincident with the next vram_read_char. Same with display_enable=0 -> snow stays 0.
